hop_sched_ctrl: RTL and testbench
=================================

// Module: hop_sched_ctrl
// PURPOSE
//  Sequences a frequency-hopping tag-chip transmission over NUM_HOPS hops. Per hop: fetch the IF hop code from the code table,
//  hand it to the scan-chain loader (valid/ready), wait for load_done, then hold sync and TX windows. Drives the hop phase
//  increment to the mtx signal generator. Sits between the top-level tag-chip controller, the code ROM and the scan loader.
// PARAMETERS
//  PHASE_WIDTH      24         width of hop_ph_inc
//  CODE_WIDTH       32         hop code width (one table entry)
//  HOP_IDX_WIDTH    6          width of hop index / table address
//  NUM_HOPS         64         hops per sweep; 1 <= NUM_HOPS <= 2**HOP_IDX_WIDTH
//  CNT_WIDTH        24         width of sync/dwell/timeout counters
//  SYNC_N           16384      sync window length, cycles
//  HOP_START_PH_INC 24'hC00000 phase increment of hop 0
//  HOP_DPH_INC      131072     per-hop phase increment step
//  LOAD_TIMEOUT     4096       max cycles waiting for load_done before error
// PORTS
//  clk          in  1               system clock
//  reset_n      in  1               asynchronous, active-low reset
//  start        in  1               pulse: begin sweep (honoured only in IDLE)
//  abort        in  1               level: return to IDLE next cycle (priority over all)
//  loop_en      in  1               1: restart at hop 0 after last hop
//  dwell_len    in  CNT_WIDTH       TX cycles per hop; sampled on accepted start
//  code_rd_en   out 1               code table read strobe
//  code_addr    out HOP_IDX_WIDTH   code table address (= hop_idx)
//  code_data    in  CODE_WIDTH      table data, valid 1 cycle after code_rd_en
//  load_valid   out 1               hop code offered to scan loader
//  load_ready   in  1               loader accepts (transfer when valid&ready)
//  load_code    out CODE_WIDTH      hop code to load
//  load_done    in  1               pulse: chip scan/load finished
//  sync_out     out 1               high during sync window
//  tx_en        out 1               high during TX window (gates itx/qtx)
//  hop_ph_inc   out PHASE_WIDTH     current hop phase increment
//  hop_idx      out HOP_IDX_WIDTH   current hop number
//  busy         out 1               high in any state but IDLE
//  sweep_done   out 1               1-cycle pulse at end of non-looping sweep
//  err          out 1               sticky: load timeout; cleared by accepted start
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except hop_ph_inc=HOP_START_PH_INC; all outputs registered.
//  States: IDLE, FETCH, CAPT, LOAD, WAIT, SYNC, TX.
//  IDLE: start -> FETCH; hop_idx<=0, hop_ph_inc<=HOP_START_PH_INC, latch dwell_len (0 treated as 1), err<=0.
//  FETCH: code_rd_en=1 one cycle, code_addr=hop_idx -> CAPT.
//  CAPT: load_code<=code_data, load_valid<=1 -> LOAD. load_code stable while load_valid=1.
//  LOAD: when load_valid&load_ready: load_valid<=0, timer<=LOAD_TIMEOUT -> WAIT. No timeout in LOAD.
//  WAIT: load_done -> SYNC, timer<=SYNC_N; timer reaches 0 first -> err<=1, IDLE.
//   load_done arriving in the same cycle as the handshake is missed; the loader must not do this.
//  SYNC: sync_out=1 for exactly SYNC_N cycles -> TX, timer<=dwell.
//  TX: tx_en=1 for exactly dwell cycles, then:
//   hop_idx<NUM_HOPS-1: hop_idx+1, hop_ph_inc+=HOP_DPH_INC (mod 2^PHASE_WIDTH) -> FETCH.
//   last hop and loop_en=1: hop_idx<=0, hop_ph_inc<=HOP_START_PH_INC -> FETCH.
//   last hop and loop_en=0: sweep_done pulse -> IDLE.
//   loop_en is sampled at the last TX cycle.
//  sync_out and tx_en are never high together; both are 0 from FETCH through WAIT.
//  abort=1: next cycle IDLE, load_valid/sync_out/tx_en/code_rd_en <= 0; hop_idx and hop_ph_inc hold; err unchanged.
//  start outside IDLE is ignored; start&abort together -> IDLE.
//  Async reset mid-sweep -> reset values immediately; no handshake completion.
//  Ignored inputs: load_done outside WAIT; load_ready while load_valid=0.
// STRUCTURE
//  Package hop_sched_pkg holds:
//   - state encoding localparams;
//   - default HOP_START_PH_INC, HOP_DPH_INC, SYNC_N, NUM_HOPS;
//   - the function next_ph_inc().
//  Sub-module sched_timer (loadable down-counter, CNT_WIDTH, load/en/zero flag) is shared by WAIT, SYNC and TX.
// TESTING
//  1. NUM_HOPS=4, SYNC_N=8, dwell=5, ready tied 1, done 3 cycles after accept:
//     4 hops; hop_ph_inc C00000, C20000, C40000, C60000; sweep_done once.
//  2. Code ROM addr k = 0xA5000000+k: load_code matches per hop; code_rd_en exactly once per hop.
//  3. load_ready delayed 7 cycles: load_valid/load_code held stable; one transfer per hop.
//  4. load_done never sent, LOAD_TIMEOUT=16: err=1, busy=0 after 16 WAIT cycles; next start clears err.
//  5. abort asserted mid-TX of hop 2: IDLE next cycle, tx_en=0, hop_idx=2 held; restart begins hop 0.
//  6. loop_en=1, dwell=0: each TX lasts 1 cycle; after hop 3 wraps to hop 0, ph_inc=C00000; no sweep_done.

Source files
------------

// File: rtl/hop_sched_pkg.sv
// Shared definitions for the hop scheduler: FSM state encoding, default
// sweep constants and the phase-increment step function.
package hop_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_CAPT  = 3'd2,
    S_LOAD  = 3'd3,
    S_WAIT  = 3'd4,
    S_SYNC  = 3'd5,
    S_TX    = 3'd6
  } state_t;

  localparam int unsigned DEF_NUM_HOPS         = 64;
  localparam int unsigned DEF_SYNC_N           = 16384;
  localparam logic [23:0] DEF_HOP_START_PH_INC = 24'hC00000;
  localparam int unsigned DEF_HOP_DPH_INC      = 131072;

  // Wide arithmetic; the caller truncates to its phase width, which gives the modulo wrap.
  function automatic logic [63:0] next_ph_inc(input logic [63:0] cur, input logic [63:0] step);
    return cur + step;
  endfunction

endpackage

// File: rtl/hop_sched_ctrl_timer.sv
// Loadable down-counter with a zero flag; load wins over count enable and
// the count saturates at zero.
module sched_timer #(
  parameter int unsigned CNT_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_load,
  input  logic [CNT_WIDTH-1:0] i_load_val,
  input  logic                 i_en,
  output logic                 o_zero
);

  logic [CNT_WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/hop_sched_ctrl.sv
// Frequency-hop sweep sequencer: per hop it fetches the code, hands it to the
// scan loader, waits for load completion, then runs the sync and TX windows.
module hop_sched_ctrl
  import hop_sched_pkg::*;
#(
  parameter int unsigned PHASE_WIDTH                  = 24,
  parameter int unsigned CODE_WIDTH                   = 32,
  parameter int unsigned HOP_IDX_WIDTH                = 6,
  parameter int unsigned NUM_HOPS                     = DEF_NUM_HOPS,
  parameter int unsigned CNT_WIDTH                    = 24,
  parameter int unsigned SYNC_N                       = DEF_SYNC_N,
  parameter logic [PHASE_WIDTH-1:0] HOP_START_PH_INC  = DEF_HOP_START_PH_INC,
  parameter int unsigned HOP_DPH_INC                  = DEF_HOP_DPH_INC,
  parameter int unsigned LOAD_TIMEOUT                 = 4096
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     loop_en,
  input  logic [CNT_WIDTH-1:0]     dwell_len,
  output logic                     code_rd_en,
  output logic [HOP_IDX_WIDTH-1:0] code_addr,
  input  logic [CODE_WIDTH-1:0]    code_data,
  output logic                     load_valid,
  input  logic                     load_ready,
  output logic [CODE_WIDTH-1:0]    load_code,
  input  logic                     load_done,
  output logic                     sync_out,
  output logic                     tx_en,
  output logic [PHASE_WIDTH-1:0]   hop_ph_inc,
  output logic [HOP_IDX_WIDTH-1:0] hop_idx,
  output logic                     busy,
  output logic                     sweep_done,
  output logic                     err
);

  // Timer is loaded with N-1 on entry so a window lasts exactly N cycles.
  localparam logic [HOP_IDX_WIDTH-1:0] LAST_HOP = HOP_IDX_WIDTH'(NUM_HOPS - 1);
  localparam logic [CNT_WIDTH-1:0]     TMO_LD   = CNT_WIDTH'(LOAD_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0]     SYNC_LD  = CNT_WIDTH'(SYNC_N - 1);

  state_t                   r_state, w_state_next;
  logic [HOP_IDX_WIDTH-1:0] r_hop_idx, w_hop_idx_next;
  logic [PHASE_WIDTH-1:0]   r_ph, w_ph_next;
  logic [CNT_WIDTH-1:0]     r_dwell, w_dwell_next;
  logic [CODE_WIDTH-1:0]    r_code, w_code_next;
  logic                     r_err, w_err_next;
  logic                     w_sweep_done_next;
  logic                     r_code_rd_en, r_load_valid, r_sync, r_tx, r_busy, r_sweep_done;
  logic                     w_tmr_load, w_tmr_en, w_tmr_zero;
  logic [CNT_WIDTH-1:0]     w_tmr_val;

  sched_timer #(.CNT_WIDTH(CNT_WIDTH)) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_en       (w_tmr_en),
    .o_zero     (w_tmr_zero)
  );

  always_comb begin
    w_state_next      = r_state;
    w_hop_idx_next    = r_hop_idx;
    w_ph_next         = r_ph;
    w_dwell_next      = r_dwell;
    w_code_next       = r_code;
    w_err_next        = r_err;
    w_sweep_done_next = 1'b0;
    w_tmr_load        = 1'b0;
    w_tmr_val         = '0;
    w_tmr_en          = 1'b0;
    if (abort) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_next   = S_FETCH;
            w_hop_idx_next = '0;
            w_ph_next      = HOP_START_PH_INC;
            w_dwell_next   = (dwell_len == '0) ? CNT_WIDTH'(1) : dwell_len;
            w_err_next     = 1'b0;
          end
        end
        S_FETCH: w_state_next = S_CAPT;
        S_CAPT: begin
          w_code_next  = code_data;
          w_state_next = S_LOAD;
        end
        S_LOAD: begin
          if (r_load_valid && load_ready) begin
            w_state_next = S_WAIT;
            w_tmr_load   = 1'b1;
            w_tmr_val    = TMO_LD;
          end
        end
        S_WAIT: begin
          w_tmr_en = 1'b1;
          if (load_done) begin
            w_state_next = S_SYNC;
            w_tmr_load   = 1'b1;
            w_tmr_val    = SYNC_LD;
          end else if (w_tmr_zero) begin
            w_err_next   = 1'b1;
            w_state_next = S_IDLE;
          end
        end
        S_SYNC: begin
          w_tmr_en = 1'b1;
          if (w_tmr_zero) begin
            w_state_next = S_TX;
            w_tmr_load   = 1'b1;
            w_tmr_val    = r_dwell - 1'b1;
          end
        end
        S_TX: begin
          w_tmr_en = 1'b1;
          if (w_tmr_zero) begin
            if (r_hop_idx != LAST_HOP) begin
              w_hop_idx_next = r_hop_idx + 1'b1;
              w_ph_next      = PHASE_WIDTH'(next_ph_inc(64'(r_ph), 64'(HOP_DPH_INC)));
              w_state_next   = S_FETCH;
            end else if (loop_en) begin
              w_hop_idx_next = '0;
              w_ph_next      = HOP_START_PH_INC;
              w_state_next   = S_FETCH;
            end else begin
              w_sweep_done_next = 1'b1;
              w_state_next      = S_IDLE;
            end
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Strobes are decoded from the next state so every output is a flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_hop_idx    <= '0;
      r_ph         <= HOP_START_PH_INC;
      r_dwell      <= CNT_WIDTH'(1);
      r_code       <= '0;
      r_err        <= 1'b0;
      r_code_rd_en <= 1'b0;
      r_load_valid <= 1'b0;
      r_sync       <= 1'b0;
      r_tx         <= 1'b0;
      r_busy       <= 1'b0;
      r_sweep_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_hop_idx    <= w_hop_idx_next;
      r_ph         <= w_ph_next;
      r_dwell      <= w_dwell_next;
      r_code       <= w_code_next;
      r_err        <= w_err_next;
      r_code_rd_en <= (w_state_next == S_FETCH);
      r_load_valid <= (w_state_next == S_LOAD);
      r_sync       <= (w_state_next == S_SYNC);
      r_tx         <= (w_state_next == S_TX);
      r_busy       <= (w_state_next != S_IDLE);
      r_sweep_done <= w_sweep_done_next;
    end
  end

  assign code_rd_en = r_code_rd_en;
  assign code_addr  = r_hop_idx;
  assign load_valid = r_load_valid;
  assign load_code  = r_code;
  assign sync_out   = r_sync;
  assign tx_en      = r_tx;
  assign hop_ph_inc = r_ph;
  assign hop_idx    = r_hop_idx;
  assign busy       = r_busy;
  assign sweep_done = r_sweep_done;
  assign err        = r_err;

endmodule

// File: tb/tb_hop_sched_ctrl.sv
// Directed bench for hop_sched_ctrl with a 4-hop sweep, a code ROM model and
// a scan-loader model with configurable ready delay and done latency.
module tb_hop_sched_ctrl;

  localparam int PW = 24;
  localparam int CW = 32;
  localparam int IW = 6;
  localparam int NW = 24;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          loop_en = 1'b0;
  logic [NW-1:0] dwell_len = 24'd5;
  logic          code_rd_en;
  logic [IW-1:0] code_addr;
  logic [CW-1:0] code_data = '0;
  logic          load_valid;
  logic          load_ready;
  logic [CW-1:0] load_code;
  logic          load_done;
  logic          sync_out, tx_en, busy, sweep_done, err;
  logic [PW-1:0] hop_ph_inc;
  logic [IW-1:0] hop_idx;

  int n_cmp = 0;
  int n_mis = 0;

  int ready_delay = 0;
  int done_delay  = 3;
  bit done_en     = 1'b1;
  int vcnt, dcnt;

  int n_rd = 0, n_xfer = 0, n_sync = 0, n_tx = 0, n_both = 0, n_done = 0, n_unstable = 0;
  logic [IW-1:0] addr_log [64];
  logic [PW-1:0] ph_log   [64];
  logic [CW-1:0] code_log [64];
  logic          pv = 1'b0, px = 1'b0;
  logic [CW-1:0] pc = '0;

  hop_sched_ctrl #(
    .NUM_HOPS     (4),
    .SYNC_N       (8),
    .LOAD_TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .loop_en    (loop_en),
    .dwell_len  (dwell_len),
    .code_rd_en (code_rd_en),
    .code_addr  (code_addr),
    .code_data  (code_data),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_code  (load_code),
    .load_done  (load_done),
    .sync_out   (sync_out),
    .tx_en      (tx_en),
    .hop_ph_inc (hop_ph_inc),
    .hop_idx    (hop_idx),
    .busy       (busy),
    .sweep_done (sweep_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Code ROM: registered read, entry k holds 0xA5000000 + k.
  always @(posedge clk) begin
    if (code_rd_en) code_data <= 32'hA500_0000 + {26'd0, code_addr};
  end

  // Scan loader: ready after ready_delay cycles of valid, done pulse done_delay cycles after accept.
  assign load_ready = (ready_delay == 0) ? 1'b1 : (load_valid && (vcnt >= ready_delay));

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vcnt      <= 0;
      dcnt      <= 0;
      load_done <= 1'b0;
    end else begin
      vcnt      <= (load_valid && !load_ready) ? vcnt + 1 : 0;
      load_done <= 1'b0;
      if (load_valid && load_ready) begin
        dcnt <= done_delay;
      end else if (dcnt > 0) begin
        dcnt <= dcnt - 1;
        if (dcnt == 1 && done_en) load_done <= 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (code_rd_en) begin
      if (n_rd < 64) begin
        addr_log[n_rd] <= code_addr;
        ph_log[n_rd]   <= hop_ph_inc;
      end
      n_rd <= n_rd + 1;
    end
    if (load_valid && load_ready) begin
      if (n_xfer < 64) code_log[n_xfer] <= load_code;
      n_xfer <= n_xfer + 1;
    end
    if (sync_out) n_sync <= n_sync + 1;
    if (tx_en) n_tx <= n_tx + 1;
    if (sync_out && tx_en) n_both <= n_both + 1;
    if (sweep_done) n_done <= n_done + 1;
    if (load_valid && pv && !px && (load_code !== pc)) n_unstable <= n_unstable + 1;
    pv <= load_valid;
    px <= load_valid && load_ready;
    pc <= load_code;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int b_rd, b_xfer, b_done;
    logic [PW-1:0] exp_ph;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_ph", hop_ph_inc, 24'hC00000);
    check("rst_idx", hop_idx, 0);
    check("rst_valid", load_valid, 0);
    check("rst_rd", code_rd_en, 0);
    check("rst_sync_tx", {sync_out, tx_en, sweep_done, err}, 0);
    reset_n = 1'b1;
    tick();

    // Basic sweep: 20 cycles per hop, sweep_done in the cycle after the last TX.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1_rd", code_rd_en, 1);
    check("t1_busy", busy, 1);
    n = 1;
    while (!sweep_done && n < 1000) begin
      tick();
      n++;
    end
    check("t1_sweep_cycles", n, 81);
    tick();
    check("t1_done_pulse", sweep_done, 0);
    check("t1_idle", busy, 0);
    check("t1_n_rd", n_rd, 4);
    check("t1_n_xfer", n_xfer, 4);
    check("t1_n_sync", n_sync, 32);
    check("t1_n_tx", n_tx, 20);
    check("t1_n_done", n_done, 1);
    check("t1_overlap", n_both, 0);
    for (int k = 0; k < 4; k++) begin
      exp_ph = 24'hC00000 + 24'(k) * 24'h020000;
      check($sformatf("t1_ph%0d", k), ph_log[k], exp_ph);
      check($sformatf("t2_addr%0d", k), addr_log[k], k);
      check($sformatf("t2_code%0d", k), code_log[k], 32'hA500_0000 + k);
    end

    // Loader ready delayed 7 cycles: LOAD holds 8 cycles, 27 per hop.
    ready_delay = 7;
    b_rd = n_rd;
    b_xfer = n_xfer;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!sweep_done && n < 2000) begin
      tick();
      n++;
    end
    check("t3_sweep_cycles", n, 109);
    tick();
    check("t3_xfers", n_xfer - b_xfer, 4);
    check("t3_reads", n_rd - b_rd, 4);
    check("t3_stable", n_unstable, 0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t3_code%0d", k), code_log[4 + k], 32'hA500_0000 + k);
    end

    // load_done withheld: 16 WAIT cycles then err and IDLE.
    ready_delay = 0;
    done_en = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (18) tick();
    check("t4_err_before", err, 0);
    check("t4_busy_before", busy, 1);
    tick();
    check("t4_err", err, 1);
    check("t4_busy", busy, 0);
    done_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_err_clr", err, 0);
    check("t4_restart_busy", busy, 1);

    // Abort in the middle of hop 2 TX.
    n = 0;
    while (!(hop_idx == 2 && tx_en) && n < 300) begin
      tick();
      n++;
    end
    check("t5_reach_tx2", n < 300, 1);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_tx", tx_en, 0);
    check("t5_idx", hop_idx, 2);
    check("t5_ph", hop_ph_inc, 24'hC40000);
    check("t5_err", err, 0);
    tick();
    check("t5_stay_idle", busy, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_restart_idx", hop_idx, 0);
    check("t5_restart_ph", hop_ph_inc, 24'hC00000);
    check("t5_restart_rd", {code_rd_en, code_addr}, {1'b1, 6'd0});
    repeat (3) tick();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("t5_start_abort", busy, 0);
    tick();
    check("t5_start_abort_idle", busy, 0);

    // Looping with dwell 0: single-cycle TX, wrap after hop 3, no sweep_done.
    loop_en = 1'b1;
    dwell_len = '0;
    b_done = n_done;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!(hop_idx == 3 && tx_en) && n < 300) begin
      tick();
      n++;
    end
    check("t6_reach_tx3", n < 300, 1);
    check("t6_ph3", hop_ph_inc, 24'hC60000);
    tick();
    check("t6_tx_1cyc", tx_en, 0);
    check("t6_wrap_idx", hop_idx, 0);
    check("t6_wrap_ph", hop_ph_inc, 24'hC00000);
    check("t6_wrap_rd", code_rd_en, 1);
    check("t6_busy", busy, 1);
    repeat (3) tick();
    check("t6_no_done", n_done - b_done, 0);

    // Asynchronous reset during the sync window.
    n = 0;
    while (!sync_out && n < 100) begin
      tick();
      n++;
    end
    check("t7_reach_sync", sync_out, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t7_rst_busy", busy, 0);
    check("t7_rst_sync", sync_out, 0);
    check("t7_rst_ph", hop_ph_inc, 24'hC00000);
    loop_en = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    check("t7_after_rst", {busy, load_valid, code_rd_en}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
